// File: rtl/chnl_rx.sv
`default_nettype none
// ============================================================================
//  Module      : chnl_rx
//  Description : Buffered Riffa CHNL receiver. Accepts host-to-FPGA
//                transactions, buffers PCIe beats in a FIFO, and unpacks
//                them into RX_WIDTH-bit words on a val/rdy stream.
//                Optional macro CHNL_RX_STATS_EN adds transfer/word counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module chnl_rx #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int FIFO_AW          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [RX_WIDTH-1:0]         o_data,
`ifdef CHNL_RX_STATS_EN
    output logic [31:0]                 o_rx_xfers,
    output logic [31:0]                 o_rx_words,
`endif
    output logic                        o_err
);

    localparam int c_BEAT_WORDS = C_PCI_DATA_WIDTH / 32;
    localparam int c_RX_WORDS   = RX_WIDTH / 32;
    localparam int c_BUF_WORDS  = c_RX_WORDS + c_BEAT_WORDS;
    localparam int c_BUF_BITS   = c_BUF_WORDS * 32;
    localparam int c_CW         = $clog2(c_BEAT_WORDS + 1);
    localparam int c_BCW        = $clog2(c_BUF_WORDS + 1);
    localparam int c_BCW1       = c_BCW + 1;
    localparam int c_FCW        = FIFO_AW + 1;
    localparam int c_DEPTH      = 1 << FIFO_AW;

    localparam logic [31:0]      c_BEAT_WORDS32 = 32'(c_BEAT_WORDS);
    localparam logic [c_BCW-1:0] c_RX_CNT       = c_BCW'(c_RX_WORDS);
    localparam logic [c_BCW:0]   c_BUF_CNT      = c_BCW1'(c_BUF_WORDS);
    localparam logic [FIFO_AW:0] c_FULL_CNT     = c_FCW'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_RECV = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    // Transaction FSM state
    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_beats;
    logic [31:0] r_words;
    logic        r_tag;

    // FIFO storage: beat, valid-word count, last-beat flag, transaction tag
    logic [C_PCI_DATA_WIDTH-1:0] r_mem_data [c_DEPTH];
    logic [c_CW-1:0]             r_mem_cnt  [c_DEPTH];
    logic                        r_mem_last [c_DEPTH];
    logic                        r_mem_tag  [c_DEPTH];
    logic [FIFO_AW-1:0]          r_wptr;
    logic [FIFO_AW-1:0]          r_rptr;
    logic [FIFO_AW:0]            r_fcount;

    // Unpacker staging buffer and output register
    logic [c_BUF_BITS-1:0] r_buf;
    logic [c_BCW-1:0]      r_bcnt;
    logic                  r_eot;
    logic                  r_btag;
    logic                  r_oval;
    logic [RX_WIDTH-1:0]   r_odata;
    logic                  r_err;

    logic [31:0]                 w_req_beats;
    logic [c_CW-1:0]             w_beat_cnt;
    logic                        w_full;
    logic                        w_wr;
    logic                        w_abort;
    logic                        w_fifo_empty;
    logic [C_PCI_DATA_WIDTH-1:0] w_head_data;
    logic [c_CW-1:0]             w_head_cnt;
    logic                        w_head_last;
    logic                        w_head_tag;
    logic [C_PCI_DATA_WIDTH-1:0] w_head_masked;
    logic                        w_emit;
    logic [c_BCW-1:0]            w_bcnt_e;
    logic [c_BUF_BITS-1:0]       w_buf_e;
    logic                        w_tag_new;
    logic                        w_disc;
    logic [c_BCW-1:0]            w_base_cnt;
    logic [c_BUF_BITS-1:0]       w_base_buf;
    logic [c_BCW:0]              w_fill;
    logic                        w_pop;
    logic                        w_flush;
    logic [c_BUF_BITS-1:0]       w_app_buf;
    logic                        w_unused_ok;

    assign CHNL_RX_CLK = clk;
    assign w_unused_ok = &{1'b0, CHNL_RX_LAST, CHNL_RX_OFF};

    // ceil(LEN/W) without overflow; last beat carries whatever words remain
    assign w_req_beats = (CHNL_RX_LEN / c_BEAT_WORDS32)
                       + {31'd0, (CHNL_RX_LEN % c_BEAT_WORDS32) != 32'd0};
    assign w_beat_cnt  = (r_words >= c_BEAT_WORDS32) ? c_CW'(c_BEAT_WORDS)
                                                     : r_words[c_CW-1:0];

    assign w_full           = (r_fcount == c_FULL_CNT);
    assign CHNL_RX_DATA_REN = (r_state == S_RECV) && !w_full;
    assign w_wr             = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
    assign w_abort          = (r_state == S_RECV) && !w_wr && !CHNL_RX && !CHNL_RX_DATA_VALID;
    assign CHNL_RX_ACK      = r_ack;

    // Request handshake, beat counting and early-termination detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_beats <= 32'd0;
            r_words <= 32'd0;
            r_tag   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CHNL_RX) begin
                        r_words <= CHNL_RX_LEN;
                        r_beats <= w_req_beats;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_tag   <= ~r_tag;
                    r_state <= (r_beats == 32'd0) ? S_WAIT : S_RECV;
                end
                S_RECV: begin
                    if (w_wr) begin
                        r_beats <= r_beats - 32'd1;
                        r_words <= r_words - 32'(w_beat_cnt);
                        if (r_beats == 32'd1) r_state <= S_WAIT;
                    end else if (w_abort) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!CHNL_RX) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage writes; contents need no reset since occupancy is tracked
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[r_wptr] <= CHNL_RX_DATA;
            r_mem_cnt[r_wptr]  <= w_beat_cnt;
            r_mem_last[r_wptr] <= (r_beats == 32'd1);
            r_mem_tag[r_wptr]  <= r_tag;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_fcount <= r_fcount + 1'b1;
                2'b01:   r_fcount <= r_fcount - 1'b1;
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    assign w_fifo_empty = (r_fcount == '0);
    assign w_head_data  = r_mem_data[r_rptr];
    assign w_head_cnt   = r_mem_cnt[r_rptr];
    assign w_head_last  = r_mem_last[r_rptr];
    assign w_head_tag   = r_mem_tag[r_rptr];

    // Zero the words past the beat's valid count so they never reach o_data
    always_comb begin
        w_head_masked = '0;
        for (int i = 0; i < c_BEAT_WORDS; i++) begin
            if (i < int'(w_head_cnt)) w_head_masked[i*32 +: 32] = w_head_data[i*32 +: 32];
        end
    end

    // A full output word leaves the buffer whenever the output register is free.
    // A buffered partial word from an older transaction is dropped when the
    // next transaction's first beat arrives; a full word is never dropped.
    assign w_emit     = (r_bcnt >= c_RX_CNT) && (!r_oval || o_rdy);
    assign w_bcnt_e   = w_emit ? (r_bcnt - c_RX_CNT) : r_bcnt;
    assign w_buf_e    = w_emit ? (r_buf >> RX_WIDTH) : r_buf;
    assign w_tag_new  = (w_head_tag != r_btag);
    assign w_disc     = w_tag_new && (w_bcnt_e != '0);
    assign w_base_cnt = w_disc ? '0 : w_bcnt_e;
    assign w_base_buf = w_disc ? '0 : w_buf_e;
    assign w_fill     = {1'b0, w_base_cnt} + c_BCW1'(w_head_cnt);
    assign w_pop      = !w_fifo_empty && !r_eot
                     && !(w_tag_new && (w_bcnt_e >= c_RX_CNT))
                     && (w_fill <= c_BUF_CNT);
    assign w_flush    = r_eot && (w_bcnt_e < c_RX_CNT);
    assign w_app_buf  = w_base_buf | (c_BUF_BITS'(w_head_masked) << {w_base_cnt, 5'd0});

    // Unpacker: append popped beats, emit assembled words, flush at end of transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_bcnt  <= '0;
            r_eot   <= 1'b0;
            r_btag  <= 1'b0;
            r_oval  <= 1'b0;
            r_odata <= '0;
        end else begin
            if (w_emit) begin
                r_odata <= r_buf[RX_WIDTH-1:0];
                r_oval  <= 1'b1;
            end else if (o_rdy) begin
                r_oval  <= 1'b0;
            end

            if (w_flush) begin
                r_buf  <= '0;
                r_bcnt <= '0;
                r_eot  <= 1'b0;
            end else if (w_pop) begin
                r_buf  <= w_app_buf;
                r_bcnt <= w_fill[c_BCW-1:0];
                r_eot  <= w_head_last;
                r_btag <= w_head_tag;
            end else begin
                r_buf  <= w_buf_e;
                r_bcnt <= w_bcnt_e;
            end
        end
    end

    // Sticky error: early termination or a discarded partial word
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= r_err | w_abort | (w_pop && w_disc) | (w_flush && (w_bcnt_e != '0));
    end

    assign o_val  = r_oval;
    assign o_data = r_odata;
    assign o_err  = r_err;

`ifdef CHNL_RX_STATS_EN
    logic [31:0] r_rx_xfers;
    logic [31:0] r_rx_words;

    // Transfer and word counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_xfers <= 32'd0;
            r_rx_words <= 32'd0;
        end else begin
            if (r_state == S_ACK) r_rx_xfers <= r_rx_xfers + 32'd1;
            if (w_wr)             r_rx_words <= r_rx_words + 32'(w_beat_cnt);
        end
    end

    assign o_rx_xfers = r_rx_xfers;
    assign o_rx_words = r_rx_words;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chnl_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chnl_rx
//  Description : Scoreboard bench for chnl_rx. Two instances share one host
//                stream: 64-bit PCIe with 32-bit and with 96-bit output words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chnl_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        chnl_rx;
    logic [31:0] len_i;
    logic [63:0] data_i;
    logic        drv_valid;
    logic        valid_i;
    logic        rxclk_a, ack_a, ren_a, val_a, rdy_a, err_a;
    logic        rxclk_b, ack_b, ren_b, val_b, rdy_b, err_b;
    logic [31:0] data_a;
    logic [95:0] data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;
    int ack_cnt_a = 0;
    int ack_cnt_b = 0;
    int beats_done = 0;
    int rdy_mode = 2;
    logic exp_err_a = 1'b0;
    logic exp_err_b = 1'b0;
    logic [95:0] expq_a[$];
    logic [95:0] expq_b[$];

    always #5 clk = ~clk;

    // a beat is offered only when both receivers can take it
    assign valid_i = drv_valid & ren_a & ren_b;

    chnl_rx #(.C_PCI_DATA_WIDTH(64), .RX_WIDTH(32), .FIFO_AW(4)) dut_a (
        .clk(clk), .rst(rst), .CHNL_RX_CLK(rxclk_a), .CHNL_RX(chnl_rx),
        .CHNL_RX_ACK(ack_a), .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(len_i),
        .CHNL_RX_OFF(31'd0), .CHNL_RX_DATA(data_i), .CHNL_RX_DATA_VALID(valid_i),
        .CHNL_RX_DATA_REN(ren_a), .o_val(val_a), .o_rdy(rdy_a), .o_data(data_a),
        .o_err(err_a));

    chnl_rx #(.C_PCI_DATA_WIDTH(64), .RX_WIDTH(96), .FIFO_AW(4)) dut_b (
        .clk(clk), .rst(rst), .CHNL_RX_CLK(rxclk_b), .CHNL_RX(chnl_rx),
        .CHNL_RX_ACK(ack_b), .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(len_i),
        .CHNL_RX_OFF(31'd0), .CHNL_RX_DATA(data_i), .CHNL_RX_DATA_VALID(valid_i),
        .CHNL_RX_DATA_REN(ren_b), .o_val(val_b), .o_rdy(rdy_b), .o_data(data_b),
        .o_err(err_b));

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output ready pattern: random, held low, or held high
    initial begin
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       begin rdy_a = ($urandom_range(0, 3) != 0); rdy_b = ($urandom_range(0, 3) != 0); end
                1:       begin rdy_a = 1'b0; rdy_b = 1'b0; end
                default: begin rdy_a = 1'b1; rdy_b = 1'b1; end
            endcase
        end
    end

    // Monitor: counts ACK pulses and pops/compares every output handshake
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            ack_cnt_a = 0;
            ack_cnt_b = 0;
        end else begin
            if (ack_a) ack_cnt_a++;
            if (ack_b) ack_cnt_b++;
            if (val_a && rdy_a) begin
                if (expq_a.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out_a: got unexpected word %0h, expected none", data_a);
                end else check("out_a", {64'd0, data_a}, expq_a.pop_front());
            end
            if (val_b && rdy_b) begin
                if (expq_b.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out_b: got unexpected word %0h, expected none", data_b);
                end else check("out_b", data_b, expq_b.pop_front());
            end
        end
    end

    // One host transaction; ab>0 drops the request after ab beats
    task automatic send(input int len, input int ab);
        int beats, nb, n, idx, g;
        logic [31:0] w[$];
        beats = (len + 1) / 2;
        nb    = (ab > 0) ? ab : beats;
        n     = (ab > 0) ? ab * 2 : len;
        for (int i = 0; i < nb * 2; i++) w.push_back($urandom);
        // reference: words in arrival order, grouped into whole output words
        for (int i = 0; i < n; i++) expq_a.push_back({64'd0, w[i]});
        for (int i = 0; i + 3 <= n; i += 3) expq_b.push_back({w[i+2], w[i+1], w[i]});
        if (ab > 0) exp_err_a = 1'b1;
        if (ab > 0 || (n % 3) != 0) exp_err_b = 1'b1;
        n_req++;
        beats_done = 0;

        @(negedge clk);
        chnl_rx = 1'b1;
        len_i   = len;
        g = 0;
        while (g < 20) begin
            #4;
            if (ack_a) break;
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout: got no ACK, expected one within 20 cycles");
        end
        if (len == 0) begin
            @(negedge clk);
            #4;
            check("len0_no_ren", {95'd0, ren_a}, 96'd0);
        end
        idx = 0;
        g = 0;
        while (idx < nb && g < 2000) begin
            @(negedge clk);
            drv_valid = 1'b1;
            data_i    = {w[2*idx+1], w[2*idx]};
            #4;
            if (valid_i) idx++;
            beats_done = idx;
            g++;
        end
        if (g >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL beat_timeout: got %0d beats, expected %0d", idx, nb);
        end
        @(negedge clk);
        drv_valid = 1'b0;
        chnl_rx   = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then check sticky error and ACK count
    task automatic drain();
        int g = 0;
        while ((expq_a.size() != 0 || expq_b.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d words left, expected 0", expq_a.size(), expq_b.size());
            expq_a.delete();
            expq_b.delete();
        end
        repeat (6) @(negedge clk);
        check("err_a", {95'd0, err_a}, {95'd0, exp_err_a});
        check("err_b", {95'd0, err_b}, {95'd0, exp_err_b});
        check("acks_a", 96'(ack_cnt_a), 96'(n_req));
        check("acks_b", 96'(ack_cnt_b), 96'(n_req));
    endtask

    initial begin
        int len, ab;
        rst = 1'b1; chnl_rx = 1'b0; len_i = 32'd0; data_i = 64'd0; drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack_a", {95'd0, ack_a}, 96'd0);
        check("rst_ren_a", {95'd0, ren_a}, 96'd0);
        check("rst_val_a", {95'd0, val_a}, 96'd0);
        check("rst_err_a", {95'd0, err_a}, 96'd0);
        check("rst_ren_b", {95'd0, ren_b}, 96'd0);
        check("rst_val_b", {95'd0, val_b}, 96'd0);
        rst = 1'b0;
        rdy_mode = 0;

        send(8, 0);  drain();
        send(5, 0);  drain();

        // output stalled: FIFO must throttle REN, then everything drains
        rdy_mode = 1;
        fork
            send(64, 0);
            begin
                repeat (60) @(negedge clk);
                #4;
                check("ren_throttled", {95'd0, ren_a}, 96'd0);
                check("beats_ge16", {95'd0, beats_done >= 16}, 96'd1);
                check("beats_lt32", {95'd0, beats_done < 32}, 96'd1);
                rdy_mode = 0;
            end
        join
        drain();

        send(0, 0);  drain();
        send(4, 0);  drain();
        send(8, 2);  drain();

        // reset in the middle of a transfer with buffered data
        rdy_mode = 1;
        @(negedge clk);
        chnl_rx = 1'b1;
        len_i   = 32'd20;
        repeat (3) @(negedge clk);
        drv_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1'b1; chnl_rx = 1'b0; drv_valid = 1'b0;
        expq_a.delete(); expq_b.delete();
        exp_err_a = 1'b0; exp_err_b = 1'b0; n_req = 0;
        @(negedge clk);
        check("mid_rst_val_a", {95'd0, val_a}, 96'd0);
        check("mid_rst_ren_a", {95'd0, ren_a}, 96'd0);
        check("mid_rst_ack_a", {95'd0, ack_a}, 96'd0);
        check("mid_rst_val_b", {95'd0, val_b}, 96'd0);
        rst = 1'b0;
        rdy_mode = 0;
        send(2, 0);  drain();

        for (int t = 0; t < 20; t++) begin
            rdy_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            len = $urandom_range(0, 24);
            ab  = (len > 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, (len + 1) / 2 - 1) : 0;
            send(len, ab);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
